// File: rtl/writeback_regfile_if.sv
// Bundles the memory-stage results, pipeline controls, decode read ports and
// forwarding/perf outputs of the write-back stage into one port.
interface writeback_regfile_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  ctrl_regWrite;
    logic                  ctrl_memToReg;
    logic [DATA_W-1:0]     read_data_from_mem;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [REG_ADDR_W-1:0] read_reg1;
    logic [REG_ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0]     read_data1;
    logic [DATA_W-1:0]     read_data2;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]     wb_data;
    logic [31:0]           retire_count;

    modport master (
        output ctrl_regWrite, ctrl_memToReg, read_data_from_mem, alu_result,
               write_reg, in_valid, stall, flush, read_reg1, read_reg2,
        input  read_data1, read_data2, wb_valid, wb_reg, wb_data, retire_count
    );

    modport slave (
        input  ctrl_regWrite, ctrl_memToReg, read_data_from_mem, alu_result,
               write_reg, in_valid, stall, flush, read_reg1, read_reg2,
        output read_data1, read_data2, wb_valid, wb_reg, wb_data, retire_count
    );
endinterface

// File: rtl/writeback_regfile.sv
// MIPS write-back stage: MEM/WB pipeline register, 32 x 32 register file with
// write-through bypass on both read ports, and a retired-instruction counter.
module writeback_regfile #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    writeback_regfile_if.slave bus
);
    localparam int                    NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    logic                  r_valid;
    logic                  r_done;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic [DATA_W-1:0]     r_mem_data;
    logic [DATA_W-1:0]     r_alu;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [DATA_W-1:0]     r_regs [NUM_REGS];
    logic [31:0]           r_retire_count;

    logic                  w_commit;
    logic                  w_retire;
    logic                  w_reg_we;
    logic                  w_fwd_ok;
    logic [DATA_W-1:0]     w_wb_data;
    logic [DATA_W-1:0]     w_rd1;
    logic [DATA_W-1:0]     w_rd2;

    // A held entry commits once; a flush on the commit edge discards it instead.
    assign w_commit = r_valid & ~r_done;
    assign w_retire = w_commit & ~bus.flush;
    assign w_reg_we = w_retire & r_reg_write & (r_dest != ZERO_REG);
    assign w_fwd_ok = w_commit & r_reg_write & (r_dest != ZERO_REG);

    // MEM/WB pipeline register: flush beats stall beats load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_data   <= '0;
            r_alu        <= '0;
            r_dest       <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.stall) begin
            if (w_commit) begin
                r_done <= 1'b1;
            end
        end else begin
            r_valid      <= bus.in_valid;
            r_done       <= 1'b0;
            r_reg_write  <= bus.ctrl_regWrite;
            r_mem_to_reg <= bus.ctrl_memToReg;
            r_mem_data   <= bus.read_data_from_mem;
            r_alu        <= bus.alu_result;
            r_dest       <= bus.write_reg;
        end
    end

    // Write-back source select from the registered fields.
    always_comb begin
        w_wb_data = r_alu;
        if (r_mem_to_reg) begin
            w_wb_data = r_mem_data;
        end else begin
            w_wb_data = r_alu;
        end
    end

    // Architectural register file; entry 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regs[r_dest] <= w_wb_data;
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_count <= '0;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    // Read ports with write-through bypass of the pending commit.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (bus.read_reg1 == ZERO_REG) begin
            w_rd1 = '0;
        end else if (w_fwd_ok && (r_dest == bus.read_reg1)) begin
            w_rd1 = w_wb_data;
        end else begin
            w_rd1 = r_regs[bus.read_reg1];
        end
        if (bus.read_reg2 == ZERO_REG) begin
            w_rd2 = '0;
        end else if (w_fwd_ok && (r_dest == bus.read_reg2)) begin
            w_rd2 = w_wb_data;
        end else begin
            w_rd2 = r_regs[bus.read_reg2];
        end
    end

    assign bus.read_data1   = w_rd1;
    assign bus.read_data2   = w_rd2;
    assign bus.wb_valid     = w_commit;
    assign bus.wb_reg       = r_dest;
    assign bus.wb_data      = w_wb_data;
    assign bus.retire_count = r_retire_count;
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Write-back stage and architectural register file of the MIPS pipeline, directly downstream of the memory-access stage. It latches that stage's results into a MEM/WB pipeline register and selects memory data or ALU result. It commits the selected value to a 32 x 32 register file with write-through bypass on both read ports. It also keeps a retired-instruction counter for the bench and performance checks.

## Interface

Parameters:

- DATA_W, 32, datapath and register width
- REG_ADDR_W, 5, register index width; register count = 2**REG_ADDR_W

Ports:

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ctrl_regWrite  in  1  instruction in memory stage writes a register
- ctrl_memToReg  in  1  1 = write back read_data_from_mem, 0 = alu_result
- read_data_from_mem  in  DATA_W  load data from memory-access stage
- alu_result  in  DATA_W  ALU result / address forwarded from memory-access stage
- write_reg  in  REG_ADDR_W  destination register index
- in_valid  in  1  memory stage holds a real instruction (0 = bubble)
- stall  in  1  hold MEM/WB register contents
- flush  in  1  replace MEM/WB contents with a bubble
- read_reg1, read_reg2  in  REG_ADDR_W  decode-stage read addresses
- read_data1, read_data2  out  DATA_W  read data, combinational with bypass
- wb_valid  out  1  MEM/WB entry valid and not yet committed
- wb_reg  out  REG_ADDR_W  registered destination index (forwarding unit)
- wb_data  out  DATA_W  selected write-back value (forwarding unit)
- retire_count  out  32  instructions committed since reset

## Operation

- MEM/WB register fields: valid, done, regWrite, memToReg, mem_data, alu, dest.
- Update priority at each rising clk edge: reset > flush > stall > load.
  - flush: valid=0, done=0, other fields don't-care (hold is fine).
  - stall: all fields hold, except done is set as described in the commit bullet.
  - load: capture all inputs; valid=in_valid; done=0.
- wb_data = memToReg ? mem_data : alu. This is combinational from the registered fields.
- Commit condition C = valid & ~done.
  - At the edge where C=1:
    - if regWrite and dest != 0, regs[dest] <= wb_data.
    - retire_count increments by 1, for any valid instruction regardless of regWrite.
    - if stall is also asserted, done <= 1, so a held entry commits exactly once.
- Register 0 always reads 0. Writes to it are discarded, but the instruction still counts as retired.
- Read ports: if C & regWrite & dest == read_regN & dest != 0, read_dataN = wb_data. Otherwise read_dataN = regs[read_regN], which is 0 for index 0.
- Outputs:
  - wb_valid = C.
  - wb_reg = dest.
- retire_count is 32-bit unsigned and wraps from 0xFFFF_FFFF to 0.

## Timing

- Reset (reset=0, asynchronous): all registers, all MEM/WB fields and retire_count go to 0 immediately. Resulting output values: wb_valid=0, wb_reg=0, wb_data=0, read_data1/2=0.
- Reset released mid-operation: the first edge with reset=1 performs a normal load. An in-flight write lost to reset is not replayed.
- Latency from memory-stage inputs to register file:
  - inputs are sampled at edge E;
  - bypass makes the value visible on read_data from just after E;
  - the register file is written and the count incremented at edge E+1.
- Back-to-back writes to the same register: the later instruction wins at its own commit edge. The bypass shows the current entry only.
- flush and stall together: flush wins. An uncommitted entry is discarded without a write or count, because flush takes effect at the same edge as the commit would.
- stall held N cycles on a valid entry: exactly one write and one count, at the first edge. wb_valid is then 0 for the remaining stall cycles.
- Read and write of the same register in the same cycle returns the new value through the bypass.

## Test plan

- Reset then idle: after reset, all 32 registers read 0 and retire_count=0. Assert reset mid-run with regs[5]=0x1234 → read_data1 at read_reg1=5 is 0 immediately, without waiting for a clock edge.
- ALU write and bypass: load regWrite=1, memToReg=0, alu_result=0xDEADBEEF, write_reg=8, in_valid=1 at E.
  - After E: read_reg1=8 gives read_data1=0xDEADBEEF and wb_valid=1.
  - After E+1: regs[8]=0xDEADBEEF, retire_count=1.
- Load select and $zero: memToReg=1, read_data_from_mem=0x00000042, write_reg=0.
  - read_data1 at read_reg1=0 stays 0; regs[0] stays 0.
  - retire_count increments by 1.
- Stall: load valid entry to reg 3 = 7, then hold stall=1 for 4 cycles → retire_count +1 only, regs[3]=7, wb_valid=0 after the first commit edge.
- Flush beats stall: load entry to reg 4 = 9, then at the next edge assert stall=1 and flush=1 → regs[4] unchanged (0), retire_count unchanged, wb_valid=0.
- Counter wrap: preload retire_count to 0xFFFF_FFFF (force or long run), then commit one instruction → retire_count=0.
